clk_div_bank: RTL and testbench
===============================

CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 4: number of divider channels, 1..16.
REQ-002 Parameter CNT_W, default 8: width of the divide value and the per-channel counter.
REQ-003 Parameter DEFAULT_DIV, default 5: divide value loaded into every channel at reset (50 MHz -> 10 MHz).
REQ-004 Parameter LOCK_PERIODS, default 4: channel-0 periods required before locked asserts, 1..255.
REQ-005 refclk  in  1  sole clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 cfg_valid  in  1  divide-value write request.
REQ-008 cfg_ready  out  1  block can accept a write.
REQ-009 cfg_ch  in  4  target channel index.
REQ-010 cfg_div  in  CNT_W  new divide value D.
REQ-011 cfg_err  out  1  one-cycle pulse when a write targets cfg_ch >= NUM_CH.
REQ-012 sync_i  in  1  phase-realign pulse for all channels.
REQ-013 ce_o  out  NUM_CH  per-channel clock-enable pulses.
REQ-014 divclk_o  out  NUM_CH  per-channel divided square wave.
REQ-015 locked  out  1  channel 0 is stable.

Function
REQ-016 Each channel SHALL hold D[i] and counter cnt[i]: 0..D-1, incrementing each cycle and wrapping D-1 -> 0.
REQ-017 ce_o[i] SHALL be 1 exactly in the cycles where cnt[i] == D[i]-1 (D[i] >= 1).
REQ-018 divclk_o[i] SHALL be 1 exactly in the cycles where cnt[i] < (D[i] >> 1); odd D gives the shorter high phase.
REQ-019 D == 1: ce_o[i] SHALL be constantly 1 and divclk_o[i] constantly 0.
REQ-020 D == 0: the channel SHALL be disabled, with cnt held at 0 and ce_o[i] = divclk_o[i] = 0.
REQ-021 ce_o and divclk_o SHALL be driven from flops that are glitch-free and reflect the same-cycle cnt value.
REQ-022 The config FSM SHALL have states IDLE (cfg_ready = 1) and APPLY (cfg_ready = 0).
REQ-023 A write is accepted when cfg_valid && cfg_ready; IDLE -> APPLY on accept, APPLY -> IDLE unconditionally after one cycle.
REQ-024 In the cycle after accept, D[cfg_ch] SHALL take the captured cfg_div and cnt[cfg_ch] SHALL be 0; other channels are unaffected.
REQ-025 For cfg_ch >= NUM_CH, the write SHALL be accepted but not applied, and cfg_err SHALL pulse high for the APPLY cycle.
REQ-026 sync_i = 1 SHALL clear every cnt[i] to 0 on the next edge.
REQ-027 If sync_i and an APPLY occur in the same cycle, both SHALL take effect: all counters 0 and the new D applied.
REQ-028 The lock FSM SHALL have states UNLOCKED, COUNTING and LOCKED; locked = 1 only in LOCKED.
REQ-029 Lock FSM transitions:
- UNLOCKED -> COUNTING when D[0] != 0.
- COUNTING counts ce_o[0] pulses; when the count reaches LOCK_PERIODS it goes to LOCKED, with locked rising the cycle after the final pulse.
REQ-030 An applied write to channel 0, a sync_i, or D[0] == 0 SHALL force the lock FSM to UNLOCKED and clear the pulse count on the next edge, from any state.
REQ-031 Writes to channels other than 0 SHALL NOT affect locked.

Reset
REQ-032 rst_n low SHALL asynchronously set:
- every D[i] = DEFAULT_DIV and every cnt[i] = 0;
- config FSM = IDLE, lock FSM = UNLOCKED;
- ce_o = 0, divclk_o = 0, locked = 0, cfg_err = 0, cfg_ready = 0.
REQ-033 Reset release SHALL be followed by normal counting from cnt = 0 on the first rising edge, with cfg_ready = 1 in that cycle.
REQ-034 Reset asserted mid-APPLY or mid-COUNTING SHALL abandon the operation with no residual state.

Verification
REQ-035 Defaults, release rst_n at cycle 0 -> ce_o[0] pulses at cycles 4, 9, 14, 19; divclk_o[0] high at cycles 0-1 and low at 2-4 of each period; locked rises at cycle 20.
REQ-036 Write ch 2, D = 8 -> cfg_ready low for one cycle; ce_o[2] every 8 cycles with 4 high / 4 low; channels 0, 1 and 3 unchanged; locked unchanged.
REQ-037 Write ch 0, D = 0 while LOCKED -> locked falls next edge; ce_o[0] = divclk_o[0] = 0; writing D = 5 back -> locked returns after 4 periods.
REQ-038 Write cfg_ch = 9 with NUM_CH = 4 -> cfg_err one-cycle pulse; no D changes.
REQ-039 sync_i in the same cycle as a write to ch 1, D = 3 -> all cnt = 0 next cycle; ch 1 period 3; locked drops and recounts.
REQ-040 Write ch 3, D = 1 -> ce_o[3] constantly 1 and divclk_o[3] constantly 0; rst_n pulse mid-APPLY -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/clk_div_bank.sv
// Bank of programmable clock dividers producing per-channel clock-enable pulses and
// square waves, with a config write port, global phase sync and a channel-0 lock detector.
module clk_div_bank #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned DEFAULT_DIV  = 5,
    parameter int unsigned LOCK_PERIODS = 4
) (
    input  logic              refclk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [3:0]        cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    output logic              cfg_err,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] ce_o,
    output logic [NUM_CH-1:0] divclk_o,
    output logic              locked
);

    typedef enum logic {CfgIdle, CfgApply} cfg_st_e;
    typedef enum logic [1:0] {LkUnlocked, LkCounting, LkLocked} lk_st_e;

    localparam logic [CNT_W-1:0] One      = CNT_W'(1);
    localparam logic [CNT_W-1:0] DefDiv   = CNT_W'(DEFAULT_DIV);
    localparam logic [4:0]       NumChW   = 5'(NUM_CH);
    localparam logic [7:0]       LockLast = 8'(LOCK_PERIODS - 1);

    cfg_st_e cfg_st_q, cfg_st_d;
    lk_st_e  lk_st_q, lk_st_d;
    logic    run_q;
    logic    err_q, err_d;
    logic [7:0] lk_cnt_q, lk_cnt_d;

    logic [CNT_W-1:0]  div_q [NUM_CH];
    logic [CNT_W-1:0]  div_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q [NUM_CH];
    logic [CNT_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ce_q, ce_d, dclk_q, dclk_d;
    logic [NUM_CH-1:0] wr_sel;
    logic              accept, force_unlock;

    // run_q holds the counters at 0 through the first edge after reset release
    assign cfg_ready = run_q && (cfg_st_q == CfgIdle);
    assign accept    = cfg_valid && cfg_ready;
    assign cfg_err   = err_q;
    assign ce_o      = ce_q;
    assign divclk_o  = dclk_q;
    assign locked    = (lk_st_q == LkLocked);

    // Outputs are registered from next-state values so they line up with the counter
    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = accept && ({1'b0, cfg_ch} == 5'(i));
            div_d[i]  = div_q[i];
            if (wr_sel[i]) begin
                div_d[i] = cfg_div;
            end
            if (!run_q || sync_i || wr_sel[i] || (div_q[i] == '0)) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == div_q[i] - One) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + One;
            end
            ce_d[i]   = (div_d[i] != '0) && (cnt_d[i] == div_d[i] - One);
            dclk_d[i] = cnt_d[i] < (div_d[i] >> 1);
        end
    end

    always_comb begin
        cfg_st_d = cfg_st_q;
        err_d    = 1'b0;
        unique case (cfg_st_q)
            CfgIdle: begin
                if (accept) begin
                    cfg_st_d = CfgApply;
                    err_d    = ({1'b0, cfg_ch} >= NumChW);
                end
            end
            CfgApply: cfg_st_d = CfgIdle;
            default:  cfg_st_d = CfgIdle;
        endcase
    end

    assign force_unlock = sync_i || wr_sel[0] || (div_q[0] == '0);

    always_comb begin
        lk_st_d  = lk_st_q;
        lk_cnt_d = lk_cnt_q;
        if (force_unlock) begin
            lk_st_d  = LkUnlocked;
            lk_cnt_d = '0;
        end else begin
            unique case (lk_st_q)
                LkUnlocked: lk_st_d = LkCounting;
                LkCounting: begin
                    if (ce_q[0]) begin
                        if (lk_cnt_q == LockLast) begin
                            lk_st_d  = LkLocked;
                            lk_cnt_d = '0;
                        end else begin
                            lk_cnt_d = lk_cnt_q + 8'd1;
                        end
                    end
                end
                LkLocked: lk_st_d = LkLocked;
                default: begin
                    lk_st_d  = LkUnlocked;
                    lk_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            run_q    <= 1'b0;
            cfg_st_q <= CfgIdle;
            err_q    <= 1'b0;
            lk_st_q  <= LkUnlocked;
            lk_cnt_q <= '0;
            ce_q     <= '0;
            dclk_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DefDiv;
                cnt_q[i] <= '0;
            end
        end else begin
            run_q    <= 1'b1;
            cfg_st_q <= cfg_st_d;
            err_q    <= err_d;
            lk_st_q  <= lk_st_d;
            lk_cnt_q <= lk_cnt_d;
            ce_q     <= ce_d;
            dclk_q   <= dclk_d;
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= div_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios with literal expectations
// plus randomized traffic compared each cycle against a phase/period reference model.
module tb_clk_div_bank;

    localparam int unsigned NUM_CH       = 4;
    localparam int unsigned CNT_W        = 8;
    localparam int unsigned DEFAULT_DIV  = 5;
    localparam int unsigned LOCK_PERIODS = 4;

    logic              refclk = 1'b0;
    logic              rst_n;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [3:0]        cfg_ch;
    logic [CNT_W-1:0]  cfg_div;
    logic              cfg_err;
    logic              sync_i;
    logic [NUM_CH-1:0] ce_o;
    logic [NUM_CH-1:0] divclk_o;
    logic              locked;

    clk_div_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEFAULT_DIV),
        .LOCK_PERIODS(LOCK_PERIODS)
    ) dut (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_ch   (cfg_ch),
        .cfg_div  (cfg_div),
        .cfg_err  (cfg_err),
        .sync_i   (sync_i),
        .ce_o     (ce_o),
        .divclk_o (divclk_o),
        .locked   (locked)
    );

    always #5 refclk = ~refclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: divide value and phase (cycles since period start) per channel
    int md [NUM_CH];
    int mp [NUM_CH];
    bit m_started, m_applying, m_err;
    int m_lk;      // 0 unlocked, 1 counting, 2 locked
    int m_pulses;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [NUM_CH-1:0] exp_ce();
        logic [NUM_CH-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            v[i] = m_started && (md[i] >= 1) && (mp[i] == md[i] - 1);
        return v;
    endfunction

    function automatic logic [NUM_CH-1:0] exp_div();
        logic [NUM_CH-1:0] v = '0;
        for (int i = 0; i < NUM_CH; i++)
            v[i] = m_started && (mp[i] < md[i] / 2);
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            md[i] = DEFAULT_DIV;
            mp[i] = 0;
        end
        m_started  = 0;
        m_applying = 0;
        m_err      = 0;
        m_lk       = 0;
        m_pulses   = 0;
    endtask

    task automatic model_step();
        bit acc;
        bit ce0;
        if (!rst_n) return;
        acc = cfg_valid && m_started && !m_applying;
        ce0 = exp_ce()[0];
        if (sync_i || (acc && cfg_ch == 0) || md[0] == 0) begin
            m_lk     = 0;
            m_pulses = 0;
        end else if (m_lk == 0) begin
            m_lk = 1;
        end else if (m_lk == 1 && ce0) begin
            m_pulses++;
            if (m_pulses >= int'(LOCK_PERIODS)) m_lk = 2;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr = acc && (int'(cfg_ch) == i);
            if (wr) md[i] = int'(cfg_div);
            if (!m_started || sync_i || wr || md[i] == 0) mp[i] = 0;
            else mp[i] = (mp[i] + 1) % md[i];
        end
        m_err      = acc && (int'(cfg_ch) >= int'(NUM_CH));
        m_applying = acc;
        m_started  = 1;
    endtask

    task automatic compare_all();
        chk("ce_o", 32'(ce_o), 32'(exp_ce()));
        chk("divclk_o", 32'(divclk_o), 32'(exp_div()));
        chk("locked", 32'(locked), 32'(m_lk == 2));
        chk("cfg_ready", 32'(cfg_ready), 32'(m_started && !m_applying));
        chk("cfg_err", 32'(cfg_err), 32'(m_err));
    endtask

    // One clock: model advances on the edge, outputs compared on the falling edge
    task automatic tick();
        @(posedge refclk);
        model_step();
        @(negedge refclk);
        compare_all();
    endtask

    task automatic do_write(input int ch, input int div, input bit sync);
        chk("ready_before_write", 32'(cfg_ready), 32'd1);
        cfg_valid = 1'b1;
        cfg_ch    = 4'(ch);
        cfg_div   = CNT_W'(div);
        sync_i    = sync;
        tick();
        cfg_valid = 1'b0;
        sync_i    = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = '0;
        cfg_div   = '0;
        sync_i    = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset_ce", 32'(ce_o), 32'd0);
        chk("reset_ready", 32'(cfg_ready), 32'd0);
        rst_n = 1'b1;

        // Defaults: ce0 at 4,9,14,19; divclk0 high in phases 0-1; locked from cycle 20
        for (int c = 0; c <= 20; c++) begin
            tick();
            chk("dflt_ce0", 32'(ce_o[0]), 32'(c % 5 == 4));
            chk("dflt_div0", 32'(divclk_o[0]), 32'(c % 5 < 2));
            chk("dflt_locked", 32'(locked), 32'(c >= 20));
            if (c == 0) chk("ready_first_cycle", 32'(cfg_ready), 32'd1);
        end

        // Channel 2 to divide-by-8
        do_write(2, 8, 1'b0);
        chk("ch2_ready_low", 32'(cfg_ready), 32'd0);
        chk("ch2_locked_kept", 32'(locked), 32'd1);
        chk("ch2_div_high", 32'(divclk_o[2]), 32'd1);
        for (int k = 1; k < 16; k++) begin
            tick();
            chk("ch2_ce", 32'(ce_o[2]), 32'(k % 8 == 7));
            chk("ch2_div", 32'(divclk_o[2]), 32'(k % 8 < 4));
        end
        chk("ch2_locked_after", 32'(locked), 32'd1);

        // Disable channel 0 then restore it
        do_write(0, 0, 1'b0);
        chk("ch0_off_locked", 32'(locked), 32'd0);
        chk("ch0_off_ce", 32'(ce_o[0]), 32'd0);
        chk("ch0_off_div", 32'(divclk_o[0]), 32'd0);
        repeat (6) tick();
        chk("ch0_off_ce_later", 32'(ce_o[0]), 32'd0);
        do_write(0, 5, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk("relock", 32'(locked), 32'(k >= 20));
        end

        // Out-of-range channel
        do_write(9, 7, 1'b0);
        chk("err_pulse", 32'(cfg_err), 32'd1);
        tick();
        chk("err_clear", 32'(cfg_err), 32'd0);
        chk("err_locked_kept", 32'(locked), 32'd1);

        // Sync together with a write to channel 1
        do_write(1, 3, 1'b1);
        chk("sync_div0", 32'(divclk_o[0]), 32'd1);
        chk("sync_ce1", 32'(ce_o[1]), 32'd0);
        chk("sync_locked", 32'(locked), 32'd0);
        tick();
        tick();
        chk("sync_ce1_p3", 32'(ce_o[1]), 32'd1);

        // Divide-by-1, then reset in the middle of the apply cycle
        repeat (4) tick();
        do_write(3, 1, 1'b0);
        chk("d1_ce3", 32'(ce_o[3]), 32'd1);
        chk("d1_div3", 32'(divclk_o[3]), 32'd0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_ce", 32'(ce_o), 32'd0);
        chk("midrst_div", 32'(divclk_o), 32'd0);
        chk("midrst_locked", 32'(locked), 32'd0);
        chk("midrst_ready", 32'(cfg_ready), 32'd0);
        chk("midrst_err", 32'(cfg_err), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_ch    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(4, 15))
                                                    : 4'($urandom_range(0, 3));
            cfg_div   = CNT_W'($urandom_range(0, 9));
            sync_i    = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 600) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                tick();
                rst_n = 1'b1;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
